// File: rtl/sdram_responder.sv
// Device-side model of a single x16 SDR SDRAM chip: decodes the command pins,
// tracks open rows per bank, serves reads at CAS latency 2/3 and flags protocol errors.
module sdram_responder #(
  parameter int ROW_BITS = 13,
  parameter int COL_BITS = 9,
  parameter int MEM_AW   = 14
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cke,
  input  logic        ncs,
  input  logic        nras,
  input  logic        ncas,
  input  logic        nwe,
  input  logic [1:0]  ba,
  input  logic [12:0] a,
  input  logic        dqml,
  input  logic        dqmh,
  input  logic [15:0] dq_in,
  output logic [15:0] dq_out,
  output logic [1:0]  dq_oe,
  output logic [12:0] mode_reg,
  output logic [15:0] refresh_cnt,
  output logic        err,
  output logic [2:0]  err_code
);

  typedef enum logic [2:0] {
    CMD_MRS = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_BST = 3'b110,
    CMD_NOP = 3'b111
  } cmd_e;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  oe;
  } beat_t;

  cmd_e  cmd;
  logic  cmd_vld;
  logic  rd_cmd;
  logic  wr_cmd;

  logic [3:0]                open_q, open_d;
  logic [3:0][ROW_BITS-1:0]  row_q, row_d;
  logic [12:0]               mode_q, mode_d;
  logic [15:0]               ref_q, ref_d;
  logic                      err_q, err_d;
  logic [2:0]                code_q, code_d;
  beat_t                     p1_q, p1_d, p2_q, p2_d, out_q, out_d;

  logic [15:0]       mem [0:(1<<MEM_AW)-1];
  logic [MEM_AW-1:0] mem_idx;
  logic [15:0]       rdata;
  logic [1:0]        oe_rd;
  beat_t             rd_beat;
  logic              cl3;
  logic              viol;
  logic [2:0]        vcode;

  assign cmd_vld = cke & ~ncs;
  assign cmd     = cmd_e'({nras, ncas, nwe});
  assign rd_cmd  = cmd_vld && (cmd == CMD_RD);
  assign wr_cmd  = cmd_vld && (cmd == CMD_WR);

  // Closed banks still use their last row, so the index is formed unconditionally.
  assign mem_idx = MEM_AW'({ba, row_q[ba], a[COL_BITS-1:0]});
  assign rdata   = mem[mem_idx];
  assign oe_rd   = ~{dqmh, dqml};
  assign rd_beat = '{data: {oe_rd[1] ? rdata[15:8] : 8'h00, oe_rd[0] ? rdata[7:0] : 8'h00},
                     oe:   oe_rd};
  assign cl3     = (mode_q[6:4] == 3'd3);

  always_comb begin
    open_d = open_q;
    row_d  = row_q;
    mode_d = mode_q;
    ref_d  = ref_q;
    err_d  = err_q;
    code_d = code_q;
    viol   = 1'b0;
    vcode  = '0;
    // CL3 reads enter one stage earlier so both latencies share the output register.
    p1_d   = '0;
    p2_d   = p1_q;
    out_d  = p2_q;
    if (cmd_vld) begin
      case (cmd)
        CMD_ACT: begin
          if (open_q[ba]) begin
            viol  = 1'b1;
            vcode = 3'd1;
          end
          open_d[ba] = 1'b1;
          row_d[ba]  = a[ROW_BITS-1:0];
        end
        CMD_RD, CMD_WR: begin
          if (!open_q[ba]) begin
            viol  = 1'b1;
            vcode = 3'd2;
          end
          if (a[10]) open_d[ba] = 1'b0;
          if (cmd == CMD_RD) begin
            if (cl3) p1_d = rd_beat;
            else     p2_d = rd_beat;
          end
        end
        CMD_PRE: begin
          if (a[10]) open_d = '0;
          else       open_d[ba] = 1'b0;
        end
        CMD_REF: begin
          ref_d = ref_q + 16'd1;
          if (|open_q) begin
            viol  = 1'b1;
            vcode = 3'd3;
          end
        end
        CMD_MRS: begin
          mode_d = a;
          if (a[6:4] != 3'd2 && a[6:4] != 3'd3) begin
            viol  = 1'b1;
            vcode = 3'd4;
          end else if (a[2:0] != 3'd0) begin
            viol  = 1'b1;
            vcode = 3'd5;
          end else if (|open_q) begin
            viol  = 1'b1;
            vcode = 3'd6;
          end
        end
        default: ;
      endcase
    end
    if (viol && !err_q) begin
      err_d  = 1'b1;
      code_d = vcode;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open_q <= '0;
      row_q  <= '0;
      mode_q <= 13'h020;
      ref_q  <= '0;
      err_q  <= 1'b0;
      code_q <= '0;
      p1_q   <= '0;
      p2_q   <= '0;
      out_q  <= '0;
    end else begin
      open_q <= open_d;
      row_q  <= row_d;
      mode_q <= mode_d;
      ref_q  <= ref_d;
      err_q  <= err_d;
      code_q <= code_d;
      p1_q   <= p1_d;
      p2_q   <= p2_d;
      out_q  <= out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_cmd) begin
      if (!dqml) mem[mem_idx][7:0]  <= dq_in[7:0];
      if (!dqmh) mem[mem_idx][15:8] <= dq_in[15:8];
    end
  end

  assign dq_out      = out_q.data;
  assign dq_oe       = out_q.oe;
  assign mode_reg    = mode_q;
  assign refresh_cnt = ref_q;
  assign err         = err_q;
  assign err_code    = code_q;

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder: a command-level chip model predicts every
// output each cycle, and literal checks pin the key scenarios.
module tb_sdram_responder;
  localparam int ROW_BITS = 13;
  localparam int COL_BITS = 9;
  localparam int MEM_AW   = 14;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cke = 1'b1, ncs = 1'b1, nras = 1'b1, ncas = 1'b1, nwe = 1'b1;
  logic [1:0]  ba = '0;
  logic [12:0] a = '0;
  logic        dqml = 1'b0, dqmh = 1'b0;
  logic [15:0] dq_in = '0;
  logic [15:0] dq_out;
  logic [1:0]  dq_oe;
  logic [12:0] mode_reg;
  logic [15:0] refresh_cnt;
  logic        err;
  logic [2:0]  err_code;

  sdram_responder #(.ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS), .MEM_AW(MEM_AW)) dut (
    .clk(clk), .rst_n(rst_n), .cke(cke), .ncs(ncs), .nras(nras), .ncas(ncas), .nwe(nwe),
    .ba(ba), .a(a), .dqml(dqml), .dqmh(dqmh), .dq_in(dq_in), .dq_out(dq_out), .dq_oe(dq_oe),
    .mode_reg(mode_reg), .refresh_cnt(refresh_cnt), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum {OP_ACT, OP_RD, OP_WR, OP_PRE, OP_REF, OP_MRS} op_t;

  // Chip model state
  bit          m_open[4];
  int          m_row[4];
  logic [15:0] m_mem[int];
  logic [12:0] m_mode;
  int          m_ref;
  bit          m_err;
  int          m_code;
  logic [15:0] x_data[int];
  logic [1:0]  x_oe[int];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 4; i++) begin
      m_open[i] = 1'b0;
      m_row[i]  = 0;
    end
    x_data.delete();
    x_oe.delete();
    m_mode = 13'h020;
    m_ref  = 0;
    m_err  = 1'b0;
    m_code = 0;
  endfunction

  function automatic void viol(int c);
    if (!m_err) begin
      m_err  = 1'b1;
      m_code = c;
    end
  endfunction

  function automatic bit any_open();
    return m_open[0] | m_open[1] | m_open[2] | m_open[3];
  endfunction

  function automatic int midx(int b, int col);
    return (b * (1 << (ROW_BITS + COL_BITS)) + m_row[b] * (1 << COL_BITS) + col) % (1 << MEM_AW);
  endfunction

  task automatic issue(op_t op, int b, logic [12:0] addr, logic mh = 1'b0, logic ml = 1'b0,
                       logic [15:0] din = 16'h0, bit en = 1'b1);
    int n, cl, idx, col;
    logic [15:0] w;
    logic [1:0]  oe;
    @(negedge clk);
    case (op)
      OP_ACT: {nras, ncas, nwe} = 3'b011;
      OP_RD:  {nras, ncas, nwe} = 3'b101;
      OP_WR:  {nras, ncas, nwe} = 3'b100;
      OP_PRE: {nras, ncas, nwe} = 3'b010;
      OP_REF: {nras, ncas, nwe} = 3'b001;
      default: {nras, ncas, nwe} = 3'b000;
    endcase
    ncs = 1'b0; cke = en; ba = 2'(b); a = addr; dqmh = mh; dqml = ml; dq_in = din;
    n   = cyc + 1;
    col = int'(addr) % (1 << COL_BITS);
    cl  = (m_mode[6:4] == 3'd3) ? 3 : 2;
    if (en) begin
      case (op)
        OP_ACT: begin
          if (m_open[b]) viol(1);
          m_open[b] = 1'b1;
          m_row[b]  = int'(addr) % (1 << ROW_BITS);
        end
        OP_RD: begin
          if (!m_open[b]) viol(2);
          idx = midx(b, col);
          w   = m_mem.exists(idx) ? m_mem[idx] : 16'h0;
          oe  = {~mh, ~ml};
          x_oe[n + cl - 1]   = oe;
          x_data[n + cl - 1] = {oe[1] ? w[15:8] : 8'h00, oe[0] ? w[7:0] : 8'h00};
          if (addr[10]) m_open[b] = 1'b0;
        end
        OP_WR: begin
          if (!m_open[b]) viol(2);
          idx = midx(b, col);
          w   = m_mem.exists(idx) ? m_mem[idx] : 16'h0;
          if (!ml) w[7:0]  = din[7:0];
          if (!mh) w[15:8] = din[15:8];
          m_mem[idx] = w;
          if (addr[10]) m_open[b] = 1'b0;
        end
        OP_PRE: begin
          if (addr[10]) for (int i = 0; i < 4; i++) m_open[i] = 1'b0;
          else m_open[b] = 1'b0;
        end
        OP_REF: begin
          m_ref = (m_ref + 1) % 65536;
          if (any_open()) viol(3);
        end
        default: begin
          if (addr[6:4] != 3'd2 && addr[6:4] != 3'd3) viol(4);
          if (addr[2:0] != 3'd0) viol(5);
          if (any_open()) viol(6);
          m_mode = addr;
        end
      endcase
    end
    @(posedge clk);
    #1;
    ncs = 1'b1; cke = 1'b1; {nras, ncas, nwe} = 3'b111;
  endtask

  task automatic at_next(int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("oe_in_reset", dq_oe, 2'b00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Per-cycle comparison against the model
  always @(posedge clk) begin
    #1;
    chk("dq_oe", dq_oe, x_oe.exists(cyc) ? x_oe[cyc] : 2'b00);
    chk("dq_out", dq_out, x_data.exists(cyc) ? x_data[cyc] : 16'h0);
    chk("mode_reg", mode_reg, m_mode);
    chk("refresh_cnt", refresh_cnt, 16'(m_ref));
    chk("err", err, m_err);
    chk("err_code", err_code, 3'(m_code));
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    m_reset();
    @(posedge clk);
    #2;
    chk("rst_mode", mode_reg, 13'h020);
    chk("rst_ref", refresh_cnt, 16'h0);
    chk("rst_err", {err, err_code}, 4'h0);
    chk("rst_oe", dq_oe, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    // Init sequence
    issue(OP_PRE, 0, 13'h400);
    issue(OP_REF, 0, 13'h0);
    issue(OP_REF, 0, 13'h0);
    issue(OP_MRS, 0, 13'h220);
    #1;
    chk("init_mode", mode_reg, 13'h220);
    chk("init_ref", refresh_cnt, 16'd2);
    chk("init_err", err, 1'b0);

    // Write then read with auto-precharge, CL2
    issue(OP_ACT, 1, 13'd5);
    issue(OP_WR, 1, 13'h403, 1'b0, 1'b0, 16'hA55A);
    issue(OP_ACT, 1, 13'd5);
    issue(OP_RD, 1, 13'h403);
    #1;
    chk("cl2_before", dq_oe, 2'b00);
    at_next(1);
    chk("cl2_data", dq_out, 16'hA55A);
    chk("cl2_oe", dq_oe, 2'b11);
    at_next(1);
    chk("cl2_after", dq_oe, 2'b00);

    // Byte masking
    issue(OP_ACT, 0, 13'd2);
    issue(OP_WR, 0, 13'd7, 1'b0, 1'b0, 16'hFFFF);
    issue(OP_WR, 0, 13'd7, 1'b1, 1'b0, 16'h1234);
    issue(OP_RD, 0, 13'd7);
    at_next(1);
    chk("mask_stored", dq_out, 16'hFF34);
    issue(OP_RD, 0, 13'd7, 1'b0, 1'b1);
    at_next(1);
    chk("mask_oe", dq_oe, 2'b10);
    chk("mask_data", dq_out, 16'hFF00);
    issue(OP_PRE, 0, 13'h400);

    // CL3 back-to-back reads
    issue(OP_MRS, 0, 13'h230);
    issue(OP_ACT, 2, 13'd1);
    issue(OP_WR, 2, 13'd0, 1'b0, 1'b0, 16'h1111);
    issue(OP_WR, 2, 13'd1, 1'b0, 1'b0, 16'h2222);
    issue(OP_RD, 2, 13'd0);
    issue(OP_RD, 2, 13'd1);
    #1;
    chk("cl3_before", dq_oe, 2'b00);
    at_next(1);
    chk("cl3_beat0", {dq_oe, dq_out}, {2'b11, 16'h1111});
    at_next(1);
    chk("cl3_beat1", {dq_oe, dq_out}, {2'b11, 16'h2222});
    at_next(1);
    chk("cl3_after", dq_oe, 2'b00);
    issue(OP_PRE, 0, 13'h400);

    // Command ignored while cke is low
    issue(OP_REF, 0, 13'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    #1;
    chk("cke_ignored", refresh_cnt, 16'd2);

    // Read to a closed bank, then a second violation must not overwrite the code
    issue(OP_RD, 1, 13'd3);
    #1;
    chk("closed_err", err, 1'b1);
    chk("closed_code", err_code, 3'd2);
    issue(OP_ACT, 1, 13'd5);
    issue(OP_ACT, 1, 13'd5);
    #1;
    chk("sticky_code", err_code, 3'd2);

    // Reset while a read is in flight
    issue(OP_ACT, 3, 13'd0);
    issue(OP_WR, 3, 13'd5, 1'b0, 1'b0, 16'hBEEF);
    issue(OP_RD, 3, 13'd5);
    do_reset();
    issue(OP_REF, 0, 13'h0);
    #1;
    chk("post_rst_err", err, 1'b0);
    chk("post_rst_ref", refresh_cnt, 16'd1);
    issue(OP_ACT, 3, 13'd0);
    issue(OP_RD, 3, 13'd5);
    at_next(1);
    chk("mem_kept", {dq_oe, dq_out}, {2'b11, 16'hBEEF});

    at_next(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sdram_responder.md
Name: sdram_responder

Overview:
- Synthesizable SDRAM device-side responder: decodes the SDR command bus driven by the team's SDRAM controller and answers it like a single x16 SDR chip, backed by an internal block-RAM array.
- Used in simulation benches and in on-FPGA loopback builds without external SDRAM.
- Tracks per-bank open rows, programmable CAS latency, auto-precharge and refresh.
- Flags protocol violations so controller timing/sequence bugs are caught at the pins.

Parameters:
- ROW_BITS, 13, row address width on a[].
- COL_BITS, 9, column address width on a[].
- MEM_AW, 14, backing-store word address width; index = {ba,row,col} truncated to low MEM_AW bits.

Ports:
- clk  in  1  sole clock; all pin inputs sampled on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cke  in  1  clock enable; 0 = every command ignored.
- ncs  in  1  chip select, active low; 1 = NOP.
- nras  in  1  row strobe.
- ncas  in  1  column strobe.
- nwe  in  1  write enable.
- ba  in  2  bank address.
- a  in  13  address bus: row on ACT, {A10, col} on RD/WR, mode value on MRS.
- dqml  in  1  low-byte mask.
- dqmh  in  1  high-byte mask.
- dq_in  in  16  write data from controller.
- dq_out  out  16  read data to controller.
- dq_oe  out  2  per-byte output enable ([0]=low, [1]=high).
- mode_reg  out  13  last loaded mode register.
- refresh_cnt  out  16  refresh commands accepted; wraps.
- err  out  1  sticky protocol-violation flag.
- err_code  out  3  code of the first violation.

Behaviour:
- Reset (async, rst_n low):
  - dq_out=0, dq_oe=0, mode_reg=13'h020 (CL2, BL1), refresh_cnt=0, err=0, err_code=0.
  - All banks closed; read pipeline flushed.
  - Memory contents are not cleared.
  - Reset mid-read: pending data is dropped and dq_oe=0 immediately.
- Command decode {nras,ncas,nwe}: 111 NOP, 011 ACT, 101 RD, 100 WR, 010 PRE, 001 REF, 000 MRS. Decode only when cke=1 and ncs=0.
- ACT: bank ba opens with row a[ROW_BITS-1:0]. Bank already open -> err_code 1; row is overwritten.
- RD / WR:
  - Column is a[COL_BITS-1:0]; A10=1 closes the bank after the access (auto-precharge).
  - Target bank closed -> err_code 2; access still performed using the stale row.
  - Both use dqml/dqmh sampled on the same edge as the command.
- WR: dq_in is sampled on the command edge. Each byte is written only if its mask bit is 0.
- RD:
  - Memory is read on the command edge (edge 0). Data is registered through a CL-deep pipeline.
  - dq_out and dq_oe become valid after edge CL-1 and hold for exactly one cycle, so the controller samples them at edge CL.
  - dq_oe[i] = ~mask[i] as captured with the command; masked bytes drive 0.
  - Back-to-back reads on consecutive cycles give consecutive one-cycle data beats.
  - A WR issued while a RD is in flight does not alter the data already captured by that RD.
- PRE: A10=1 closes all banks; otherwise closes bank ba. Precharging a closed bank is legal.
- REF: refresh_cnt increments. Any bank open -> err_code 3.
- MRS:
  - mode_reg <= a. CL = mode_reg[6:4].
  - CL other than 2 or 3 -> err_code 4, and CL 2 is used.
  - Burst length field mode_reg[2:0] != 0 -> err_code 5; accesses remain single-word.
  - MRS with any bank open -> err_code 6.
- err behaviour:
  - err sets on the first violation and holds until reset.
  - err_code latches that first violation only.
  - The offending command still executes as described above.
- No tRCD/tRP timing checks; the command order alone is checked.

Test Plan:
- Init sequence PRE-all, REF, REF, MRS a=13'h220 -> mode_reg=13'h220, refresh_cnt=2, err=0.
- ACT ba=1 row=5; WR col=3 A10=1 dq_in=16'hA55A masks 00; ACT ba=1 row=5; RD col=3 A10=1 with CL2 -> dq_out=16'hA55A and dq_oe=2'b11 in exactly one cycle, sampled at edge 2; bank 1 closed afterwards.
- Byte masking:
  - Write 16'h1234 over existing 16'hFFFF with dqmh=1 -> stored value 16'hFF34.
  - Read back with dqml=1 -> dq_oe=2'b10, dq_out=16'hFF00.
- MRS to CL3, then two RDs on consecutive cycles at cols 0 and 1 -> two consecutive beats, first valid after edge 2, dq_oe low before and after.
- RD to a closed bank -> err=1, err_code=2; a following ACT to an open bank leaves err_code=2.
- Assert rst_n low one cycle after a RD command -> dq_oe stays 0, err=0, all banks closed, memory contents unchanged.
